// File: rtl/fruit_pkg.sv
// Shared fruit-game definitions: game FSM state codes, spawner states,
// screen constants and the LFSR step function.
package fruit_pkg;

   localparam logic [2:0] GS_IDLE = 3'd0;
   localparam logic [2:0] GS_PLAY = 3'd1;
   localparam logic [2:0] GS_OVER = 3'd2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_PICK   = 2'd2,
      S_LAUNCH = 2'd3
   } spawn_state_e;

   localparam logic [9:0] SPAWN_X_MIN = 10'd64;
   localparam logic [3:0] VY_MIN      = 4'd8;

   // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/fruit_spawner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads SEED on rst and steps every clock.
module lfsr16
   import fruit_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] lfsr_state
);

   logic [15:0] lfsr_d;
   logic [15:0] lfsr_q;

   always_comb begin
      lfsr_d = lfsr16_next(lfsr_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_state = lfsr_q;

endmodule

// File: rtl/fruit_spawner.sv
// Fruit launch scheduler: frame-paced spawns into free slots over valid/ready.
// Optional build macro SPAWN_RAMP_EN shortens the spawn interval as game_timer grows.
module fruit_spawner
   import fruit_pkg::*;
#(
   parameter int unsigned NUM_SLOTS     = 4,
   parameter int unsigned BASE_INTERVAL = 60,
   parameter int unsigned MIN_INTERVAL  = 20,
   localparam int unsigned SLOT_W       = $clog2(NUM_SLOTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           game_state,
   input  logic [7:0]           game_timer,
   input  logic                 frame_tick,
   input  logic [NUM_SLOTS-1:0] slot_release,
   output logic                 spawn_valid,
   input  logic                 spawn_ready,
   output logic [SLOT_W-1:0]    spawn_slot,
   output logic [9:0]           spawn_x,
   output logic [3:0]           spawn_vy,
   output logic [1:0]           spawn_type,
   output logic [NUM_SLOTS-1:0] slot_busy,
   output logic [7:0]           spawn_count
);

   spawn_state_e         state_d, state_q;
   logic [7:0]           frame_cnt_d, frame_cnt_q;
   logic [7:0]           interval_d, interval_q;
   logic [NUM_SLOTS-1:0] slot_busy_d, slot_busy_q;
   logic [7:0]           spawn_count_d, spawn_count_q;
   logic                 spawn_valid_d, spawn_valid_q;
   logic [SLOT_W-1:0]    spawn_slot_d, spawn_slot_q;
   logic [9:0]           spawn_x_d, spawn_x_q;
   logic [3:0]           spawn_vy_d, spawn_vy_q;
   logic [1:0]           spawn_type_d, spawn_type_q;

   logic [15:0]          lfsr_s;
   logic [7:0]           interval_s;
   logic [SLOT_W-1:0]    pick_idx_s;
   logic                 pick_ok_s;
   logic [NUM_SLOTS-1:0] released_s;
   logic                 lfsr_unused_s;

   lfsr16 #(.SEED(16'hACE1)) u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .lfsr_state (lfsr_s)
   );

   assign lfsr_unused_s = ^{lfsr_s[13], lfsr_s[9]};

`ifdef SPAWN_RAMP_EN
   logic signed [8:0] ramp_s;
   logic              timer_unused_s;

   assign timer_unused_s = game_timer[0];

   // Signed 9-bit so a large game_timer goes negative and clamps to the floor
   always_comb begin
      ramp_s = $signed({1'b0, 8'(BASE_INTERVAL)}) - $signed({2'b00, game_timer[7:1]});
      if (ramp_s < $signed({1'b0, 8'(MIN_INTERVAL)})) begin
         interval_s = 8'(MIN_INTERVAL);
      end else begin
         interval_s = ramp_s[7:0];
      end
   end
`else
   logic timer_unused_s;

   assign timer_unused_s = ^{game_timer, 8'(MIN_INTERVAL)};
   assign interval_s     = 8'(BASE_INTERVAL);
`endif

   // Descending scan leaves the lowest free index as the winner
   always_comb begin
      pick_idx_s = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         pick_idx_s = slot_busy_q[i] ? pick_idx_s : SLOT_W'(i);
      end
   end

   assign pick_ok_s  = ~&slot_busy_q;
   assign released_s = slot_busy_q & ~slot_release;

   always_comb begin
      state_d       = state_q;
      frame_cnt_d   = frame_cnt_q;
      interval_d    = interval_q;
      slot_busy_d   = released_s;
      spawn_count_d = spawn_count_q;
      spawn_valid_d = spawn_valid_q;
      spawn_slot_d  = spawn_slot_q;
      spawn_x_d     = spawn_x_q;
      spawn_vy_d    = spawn_vy_q;
      spawn_type_d  = spawn_type_q;

      if (game_state == GS_IDLE) begin
         state_d       = S_IDLE;
         frame_cnt_d   = 8'd0;
         slot_busy_d   = '0;
         spawn_count_d = 8'd0;
         spawn_valid_d = 1'b0;
      end else if (game_state == GS_OVER) begin
         // Occupancy and count survive for the end screen
         state_d       = S_IDLE;
         frame_cnt_d   = 8'd0;
         spawn_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               frame_cnt_d = 8'd0;
               if (game_state == GS_PLAY) begin
                  state_d    = S_WAIT;
                  interval_d = interval_s;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WAIT: begin
               if (frame_tick && (frame_cnt_q == interval_q - 8'd1)) begin
                  frame_cnt_d = 8'd0;
                  state_d     = S_PICK;
               end else if (frame_tick) begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end else begin
                  frame_cnt_d = frame_cnt_q;
               end
            end
            S_PICK: begin
               if (pick_ok_s) begin
                  state_d       = S_LAUNCH;
                  spawn_valid_d = 1'b1;
                  spawn_slot_d  = pick_idx_s;
                  spawn_x_d     = {1'b0, lfsr_s[8:0]} + SPAWN_X_MIN;
                  spawn_vy_d    = VY_MIN + {1'b0, lfsr_s[12:10]};
                  spawn_type_d  = lfsr_s[15:14];
               end else begin
                  state_d = S_PICK;
               end
            end
            S_LAUNCH: begin
               if (spawn_ready) begin
                  // Set after the release mask so an accept wins a same-slot release
                  slot_busy_d   = released_s | (NUM_SLOTS'(1'b1) << spawn_slot_q);
                  spawn_count_d = (spawn_count_q == 8'hFF) ? 8'hFF : spawn_count_q + 8'd1;
                  spawn_valid_d = 1'b0;
                  state_d       = S_WAIT;
                  interval_d    = interval_s;
               end else begin
                  state_d = S_LAUNCH;
               end
            end
            default: begin
               state_d       = S_IDLE;
               spawn_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         frame_cnt_q   <= 8'd0;
         interval_q    <= 8'd0;
         slot_busy_q   <= '0;
         spawn_count_q <= 8'd0;
         spawn_valid_q <= 1'b0;
         spawn_slot_q  <= '0;
         spawn_x_q     <= 10'd0;
         spawn_vy_q    <= 4'd0;
         spawn_type_q  <= 2'd0;
      end else begin
         state_q       <= state_d;
         frame_cnt_q   <= frame_cnt_d;
         interval_q    <= interval_d;
         slot_busy_q   <= slot_busy_d;
         spawn_count_q <= spawn_count_d;
         spawn_valid_q <= spawn_valid_d;
         spawn_slot_q  <= spawn_slot_d;
         spawn_x_q     <= spawn_x_d;
         spawn_vy_q    <= spawn_vy_d;
         spawn_type_q  <= spawn_type_d;
      end
   end

   assign spawn_valid = spawn_valid_q;
   assign spawn_slot  = spawn_slot_q;
   assign spawn_x     = spawn_x_q;
   assign spawn_vy    = spawn_vy_q;
   assign spawn_type  = spawn_type_q;
   assign slot_busy   = slot_busy_q;
   assign spawn_count = spawn_count_q;

endmodule

// File: tb/tb_fruit_spawner.sv
// Randomised scoreboard bench for fruit_spawner against a round-level launch model.
module tb_fruit_spawner;

   localparam int BASE = 4;
   localparam int MINI = 2;

   logic       clk;
   logic       rst;
   logic [2:0] gs;
   logic [7:0] gt;
   logic       ft;
   logic [3:0] rel;
   logic       rdy;
   logic       spawn_valid;
   logic [1:0] spawn_slot;
   logic [9:0] spawn_x;
   logic [3:0] spawn_vy;
   logic [1:0] spawn_type;
   logic [3:0] slot_busy;
   logic [7:0] spawn_count;

   fruit_spawner #(.NUM_SLOTS(4), .BASE_INTERVAL(BASE), .MIN_INTERVAL(MINI)) dut (
      .clk          (clk),
      .rst          (rst),
      .game_state   (gs),
      .game_timer   (gt),
      .frame_tick   (ft),
      .slot_release (rel),
      .spawn_valid  (spawn_valid),
      .spawn_ready  (rdy),
      .spawn_slot   (spawn_slot),
      .spawn_x      (spawn_x),
      .spawn_vy     (spawn_vy),
      .spawn_type   (spawn_type),
      .slot_busy    (slot_busy),
      .spawn_count  (spawn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int slot;
      int x;
      int vy;
      int typ;
   } rec_t;

   rec_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   tmo = 1'b0;

   // Round-level reference: a launch is due after `interval` frame ticks,
   // needs one cycle to claim a slot, then waits for the datapath.
   localparam int P_IDLE = 0, P_WAIT = 1, P_PICK = 2, P_LAUNCH = 3;
   logic [15:0] m_lfsr;
   int          m_phase, m_ticks_left, m_count, m_slot, m_launches;
   logic [3:0]  m_busy;
   bit          m_valid;

   function automatic int interval_now(input int timer);
      int v;
      v = BASE;
`ifdef SPAWN_RAMP_EN
      v = BASE - timer / 2;
      if (v < MINI) v = MINI;
`endif
      return v;
   endfunction

   task automatic m_reset();
      m_lfsr = 16'hACE1;
      m_phase = P_IDLE;
      m_ticks_left = 0;
      m_count = 0;
      m_slot = 0;
      m_busy = 4'b0000;
      m_valid = 1'b0;
   endtask

   task automatic model_step();
      logic [15:0] cur;
      logic [3:0]  nb;
      rec_t        r;
      if (rst) begin
         m_reset();
         return;
      end
      cur = m_lfsr;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      nb = m_busy & ~rel;
      if (gs == 3'd0) begin
         m_phase = P_IDLE; m_valid = 1'b0; nb = 4'b0000; m_count = 0;
      end else if (gs == 3'd2) begin
         m_phase = P_IDLE; m_valid = 1'b0;
      end else if (m_phase == P_IDLE) begin
         m_phase = P_WAIT;
         m_ticks_left = interval_now(int'(gt));
      end else if (m_phase == P_WAIT) begin
         if (ft) begin
            m_ticks_left--;
            if (m_ticks_left == 0) m_phase = P_PICK;
         end
      end else if (m_phase == P_PICK) begin
         if (m_busy != 4'b1111) begin
            m_slot = 0;
            while (m_busy[m_slot]) m_slot++;
            r.slot = m_slot;
            r.x    = 64 + int'(cur) % 512;
            r.vy   = 8 + (int'(cur) / 1024) % 8;
            r.typ  = int'(cur) / 16384;
            sb.push_back(r);
            m_launches++;
            m_valid = 1'b1;
            m_phase = P_LAUNCH;
         end
      end else begin
         if (rdy) begin
            nb[m_slot] = 1'b1;
            m_count = (m_count < 255) ? m_count + 1 : 255;
            m_valid = 1'b0;
            m_phase = P_WAIT;
            m_ticks_left = interval_now(int'(gt));
         end
      end
      m_busy = nb;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares against the model each cycle and pops a record whenever a new request appears
   initial begin
      bit   prev_valid;
      rec_t cur;
      prev_valid = 1'b0;
      cur = '{0, 0, 0, 0};
      forever begin
         @(negedge clk);
         chk("timeout", int'(tmo), 0);
         if (rst) begin
            sb.delete();
            prev_valid = 1'b0;
            chk("rst_valid", int'(spawn_valid), 0);
            chk("rst_slot", int'(spawn_slot), 0);
            chk("rst_x", int'(spawn_x), 0);
            chk("rst_vy", int'(spawn_vy), 0);
            chk("rst_type", int'(spawn_type), 0);
            chk("rst_busy", int'(slot_busy), 0);
            chk("rst_count", int'(spawn_count), 0);
         end else begin
            chk("valid", int'(spawn_valid), int'(m_valid));
            chk("busy", int'(slot_busy), int'(m_busy));
            chk("count", int'(spawn_count), m_count);
            if (spawn_valid && !prev_valid) begin
               if (sb.size() == 0) begin
                  chk("unexpected_request", 1, 0);
               end else begin
                  cur = sb.pop_front();
                  chk("slot", int'(spawn_slot), cur.slot);
                  chk("x", int'(spawn_x), cur.x);
                  chk("vy", int'(spawn_vy), cur.vy);
                  chk("type", int'(spawn_type), cur.typ);
                  chk("x_range", int'(spawn_x >= 10'd64 && spawn_x <= 10'd575), 1);
                  chk("vy_range", int'(spawn_vy >= 4'd8), 1);
               end
            end else if (spawn_valid) begin
               chk("hold_slot", int'(spawn_slot), cur.slot);
               chk("hold_x", int'(spawn_x), cur.x);
               chk("hold_vy", int'(spawn_vy), cur.vy);
               chk("hold_type", int'(spawn_type), cur.typ);
            end
            prev_valid = spawn_valid;
         end
      end
   end

   task automatic wait_request(input int budget);
      for (int k = 0; k < budget && !m_valid; k++) begin
         ft = 1'($urandom_range(0, 1));
         rel = 4'b0000;
         cyc();
      end
      ft = 1'b0;
      if (!m_valid) tmo = 1'b1;
   endtask

   // Driver: issues stimulus and steps the reference model on every clock
   initial begin
      m_launches = 0;
      rst = 1'b1; gs = 3'd0; gt = 8'd0; ft = 1'b0; rel = 4'b0000; rdy = 1'b0;
      m_reset();
      repeat (3) cyc();
      rst = 1'b0;

      gs = 3'd1; rdy = 1'b1;
      for (int c = 0; c < 70; c++) begin
         ft = (c % 2 == 0);
         cyc();
      end
      ft = 1'b0;
      rel = 4'b0100;
      cyc();
      rel = 4'b0000;
      for (int c = 0; c < 20; c++) begin
         ft = (c % 2 == 0);
         cyc();
      end

      rel = 4'b0011; rdy = 1'b0;
      cyc();
      wait_request(200);
      repeat (10) cyc();
      rdy = 1'b1;
      repeat (3) cyc();

      rdy = 1'b0;
      rel = 4'b0100;
      cyc();
      wait_request(200);
      gs = 3'd2;
      cyc();
      rel = 4'b0010;
      cyc();
      rel = 4'b0000;
      repeat (3) cyc();
      gs = 3'd0;
      repeat (3) cyc();
      gs = 3'd1;

      for (int c = 0; c < 60000 && m_launches < 1000; c++) begin
         ft  = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 2) != 0);
         gt  = 8'($urandom_range(0, 255));
         rel = ($urandom_range(0, 2) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
         cyc();
      end
      if (m_launches < 1000) tmo = 1'b1;
      rel = 4'b0000;

      rdy = 1'b0;
      wait_request(400);
      rst = 1'b1;
      m_reset();
      repeat (2) cyc();
      rst = 1'b0;
      rdy = 1'b1; ft = 1'b1;
      repeat (30) cyc();
      ft = 1'b0;
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fruit_spawner.md
# fruit_spawner

Schedules fruit launches during a round. It sits between the game state machine and the fruit object slots. While the game is in PLAY it counts video frames, picks a free fruit slot with a fixed-priority arbiter, and draws launch parameters from an LFSR. It then issues each launch to the physics/render datapath over a valid/ready handshake. It also tracks which slots are occupied until the datapath releases them.

## Interface
- NUM_SLOTS, 4: number of fruit object slots (2..8).
- BASE_INTERVAL, 60: frame ticks between spawns at round start (1..255).
- MIN_INTERVAL, 20: interval floor when the ramp is enabled (1..BASE_INTERVAL).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- game_state  in  3  game FSM state: 0 IDLE, 1 PLAY, 2 OVER.
- game_timer  in  8  seconds elapsed in the current round.
- frame_tick  in  1  one-cycle pulse per video frame.
- slot_release  in  NUM_SLOTS  per-slot one-cycle pulse: fruit sliced or left the screen.
- spawn_valid  out  1  launch request pending.
- spawn_ready  in  1  datapath accepts the launch.
- spawn_slot  out  $clog2(NUM_SLOTS)  slot being launched.
- spawn_x  out  10  launch x position, pixels.
- spawn_vy  out  4  initial upward speed.
- spawn_type  out  2  fruit/bomb kind.
- slot_busy  out  NUM_SLOTS  occupancy mask.
- spawn_count  out  8  launches this round, saturating at 255.

## Operation
- FSM states: S_IDLE, S_WAIT, S_PICK, S_LAUNCH. Reset state is S_IDLE.
- S_IDLE
  - slot_busy, spawn_count and the frame counter are held at 0.
  - Go to S_WAIT when game_state==1.
- S_WAIT
  - The frame counter increments on each frame_tick.
  - On a frame_tick with counter==interval-1: clear the counter and go to S_PICK.
- S_PICK
  - Pick the lowest-index zero bit of slot_busy.
  - If all slots are busy, remain in S_PICK with the counter frozen.
  - On a successful pick: register slot and random fields, go to S_LAUNCH.
- S_LAUNCH
  - spawn_valid=1; all spawn_* outputs stay stable until accepted.
  - On spawn_ready: set slot_busy[slot], increment spawn_count (saturating), go to S_WAIT.
- Game-state overrides, checked in every state and taking priority over the rules above:
  - game_state==0: go to S_IDLE and clear slot_busy and spawn_count.
  - game_state==2: go to S_IDLE but keep slot_busy and spawn_count for the end screen.
  - Either override drops spawn_valid, even without spawn_ready. This is the only permitted withdrawal of a request.
- slot_release[i] clears slot_busy[i] in any state, including S_IDLE under OVER.
- A release for a slot that is not busy is ignored.
- Release and accept on the same cycle for the same slot cannot occur, because a picked slot is free. If asserted anyway, the accept (set) wins.
- Random source: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst only. It advances every clk.
- Launch fields are sampled from the LFSR value on the S_PICK→S_LAUNCH cycle:
  - spawn_x = {1'b0, lfsr[8:0]} + 64 (range 64..575).
  - spawn_vy = 8 + lfsr[12:10] (range 8..15).
  - spawn_type = lfsr[15:14].
- interval = BASE_INTERVAL (ramp disabled; see Configuration).

## Timing
- Reset values:
  - state S_IDLE; spawn_valid 0; spawn_slot 0; spawn_x 0; spawn_vy 0; spawn_type 0.
  - slot_busy 0; spawn_count 0; frame counter 0.
- First request of a round: spawn_valid rises 2 cycles after the interval-th frame_tick following entry into PLAY (one cycle in S_PICK, then S_LAUNCH).
- slot_busy updates 1 cycle after the handshake or release.
- S_PICK uses the registered slot_busy. A release in the same cycle is seen on the next cycle.
- frame_tick pulses are ignored outside S_WAIT.
- rst mid-operation: all outputs return to reset values immediately (asynchronously), and the LFSR is reseeded.

## Configuration
- SPAWN_RAMP_EN defined: interval = max(MIN_INTERVAL, BASE_INTERVAL − (game_timer>>1)).
  - The interval is sampled on entry to S_WAIT.
  - Arithmetic is 9-bit signed so negative results clamp to MIN_INTERVAL.
- SPAWN_RAMP_EN undefined: interval = BASE_INTERVAL constant; game_timer is unused.

## Structure
- Shared package fruit_pkg holds:
  - Game state constants GS_IDLE=0, GS_PLAY=1, GS_OVER=2 (also consumed by the game FSM).
  - Spawner state enum.
  - Screen constants SPAWN_X_MIN=64 and VY_MIN=8.
- Sub-module lfsr16: enable-less free-running LFSR with seed parameter, outputs the 16-bit state.

## Test plan
- rst, game_state 0→1, spawn_ready=1, BASE_INTERVAL=4 → spawn_valid after 4th frame_tick + 2 cycles, spawn_slot=0, slot_busy=4'b0001, spawn_count=1.
- Continue 3 more intervals with no releases → slots 1,2,3 in order; 5th interval → held in S_PICK, no spawn_valid; pulse slot_release[2] → next launch uses slot 2.
- spawn_ready=0 for 10 cycles in S_LAUNCH → spawn_valid and all fields stable; ready=1 → accepted once, spawn_count +1.
- game_state→2 while spawn_valid=1 → spawn_valid 0 next cycle, slot_busy preserved; game_state→0 → slot_busy=0, spawn_count=0.
- SPAWN_RAMP_EN, BASE=60, MIN=20, game_timer=59 → interval 31; game_timer=200 → interval 20.
- Check spawn_x ∈ [64,575] and spawn_vy ∈ [8,15] over 1000 launches; assert rst mid-launch → all outputs 0 and first field sample matches seed ACE1 sequence.
